irq_priority_ctrl: RTL and testbench
====================================

Name: irq_priority_ctrl

Overview:
Parametrised, clocked interrupt priority controller for the PIC datapath. It holds request (IRR), in-service (ISR) and rotation state and applies masking, fully-nested priority and optional automatic rotation. It raises a registered interrupt request toward the CPU interface and returns a vector on a single-cycle acknowledge handshake. It handles end-of-interrupt (specific, non-specific, automatic) and edge/level trigger modes for NUM_IRQ channels.

Parameters:
NUM_IRQ, 8, number of interrupt channels (2..32)
VEC_W, 8, vector width in bits
IDW (localparam), clog2(NUM_IRQ), channel index width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
irq_in  in  NUM_IRQ  raw requests, synchronous to clk
level_mode  in  1  1=level-triggered, 0=rising-edge-triggered
imr  in  NUM_IRQ  mask, 1=channel masked
auto_rotate  in  1  1=rotate priority on each EOI/auto-EOI
auto_eoi  in  1  1=ISR bit not retained on acknowledge
eoi_valid  in  1  single-cycle EOI command strobe
eoi_specific  in  1  1=specific EOI using eoi_level
eoi_level  in  IDW  channel for specific EOI
vector_base  in  VEC_W  base added to channel index
inta  in  1  single-cycle acknowledge strobe
int_req  out  1  registered interrupt request to CPU
vector_valid  out  1  one-cycle strobe, vector valid
vector  out  VEC_W  vector_base + acknowledged channel
irr  out  NUM_IRQ  request register
isr  out  NUM_IRQ  in-service register
lowest_prio  out  IDW  current lowest-priority channel

Behaviour:
- Reset, asynchronous, also mid-operation: irr=0, isr=0, irq_prev=0, int_req=0, vector_valid=0, vector=0, lowest_prio=NUM_IRQ-1, so IR0 is highest. State returns to IDLE.
- Priority order: highest is (lowest_prio+1) mod NUM_IRQ, then descending around the ring; lowest is lowest_prio.
- IRR update, per channel, each cycle:
  - Edge mode: set when irq_in=1 and irq_prev=0.
  - Level mode: set when irq_in=1; cleared when irq_in=0 and not in service.
  - Clear on acknowledge of that channel.
  - A set and an acknowledge-clear in the same cycle leave the bit set.
- Candidate: highest-priority bit of irr & ~imr. It is eligible if isr=0, or if its priority is strictly higher than the highest-priority isr bit (fully nested). Equal or lower priority never raises int_req.
- int_req is registered: it reflects eligibility one cycle later. If eligibility disappears (mask set, level drop), int_req falls the following cycle.
- FSM states: IDLE (no eligible candidate), PEND (int_req=1), ACK (vector output cycle).
  - IDLE->PEND on eligible candidate.
  - PEND->IDLE when eligibility lost.
  - PEND->ACK when inta=1. On that edge, channel n is frozen; irr[n]<=0; isr[n]<=1 unless auto_eoi; vector<=vector_base+n (mod 2^VEC_W); vector_valid<=1; int_req<=0.
  - ACK->IDLE/PEND next cycle; vector_valid lasts exactly 1 cycle; vector holds its value until the next ack.
- inta while state is not PEND: ignored; no vector_valid; no state change.
- Latency: irq_in edge sampled at cycle k -> irr at k+1 -> int_req at k+2. inta at cycle j -> vector_valid at j+1.
- EOI handling on eoi_valid:
  - Non-specific: clears the highest-priority set isr bit.
  - Specific: clears isr[eoi_level]; eoi_level>=NUM_IRQ is a no-op.
  - EOI with no matching set bit: no-op, no rotation.
- Rotation (auto_rotate=1): lowest_prio <= channel just cleared by EOI, or channel acknowledged under auto_eoi.
- Same-cycle EOI and acknowledge: EOI clear is applied to isr first, then the ack set. If both would rotate, the ack-driven rotation wins.
- int_req evaluation in the cycle after an EOI uses the updated isr and lowest_prio.

Test Plan:
- Reset/basic ack (NUM_IRQ=8, vector_base=0x20, edge mode): irq_in[3] rises -> irr=0x08, then int_req=1; inta -> vector_valid one cycle, vector=0x23, isr=0x08, irr=0x00, int_req=0.
- Fully nested: isr=0x08 (IR3 in service); irq_in[5] -> int_req stays 0; irq_in[1] -> int_req=1, ack vector=0x21, isr=0x0A; non-specific EOI clears bit1 -> isr=0x08.
- Auto-rotate: auto_rotate=1, ack IR2 then non-specific EOI -> isr=0, lowest_prio=2; simultaneous irq_in[1] and irq_in[4] -> vector=0x24 (IR4 now higher than IR1).
- Auto-EOI plus mask: auto_eoi=1, imr=0x01, irq_in=0x03 -> vector=0x21, isr stays 0x00; then imr=0x00 -> IR0 acked, vector=0x20.
- Level mode and spurious handling: level_mode=1, irq_in[6] high then low before inta -> int_req drops next cycle; late inta -> no vector_valid, state IDLE.
- Boundaries: same-cycle eoi_valid (specific, level 3) and inta with isr=0x08, candidate IR0 -> isr=0x01. Edge on IR0 during its ack cycle -> irr[0] stays 1. rst_n low mid-PEND -> all outputs reset immediately, lowest_prio=7.

Source files
------------

// File: rtl/irq_priority_ctrl.sv
// Interrupt priority controller: IRR/ISR/rotation state, masking, fully-nested
// priority, registered int_req toward the CPU and a one-cycle vector strobe on acknowledge.
module irq_priority_ctrl #(
  parameter  int NUM_IRQ = 8,
  parameter  int VEC_W   = 8,
  localparam int IDW     = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               level_mode,
  input  logic [NUM_IRQ-1:0] imr,
  input  logic               auto_rotate,
  input  logic               auto_eoi,
  input  logic               eoi_valid,
  input  logic               eoi_specific,
  input  logic [IDW-1:0]     eoi_level,
  input  logic [VEC_W-1:0]   vector_base,
  input  logic               inta,
  output logic               int_req,
  output logic               vector_valid,
  output logic [VEC_W-1:0]   vector,
  output logic [NUM_IRQ-1:0] irr,
  output logic [NUM_IRQ-1:0] isr,
  output logic [IDW-1:0]     lowest_prio
);

  typedef enum logic [1:0] {IDLE, PEND, ACK} state_t;

  state_t             state_q;
  logic [NUM_IRQ-1:0] irr_q, irr_d;
  logic [NUM_IRQ-1:0] isr_q, isr_d;
  logic [NUM_IRQ-1:0] irq_prev_q;
  logic [IDW-1:0]     lowest_q, lowest_d;
  logic               int_req_q;
  logic               vld_q;
  logic [VEC_W-1:0]   vector_q;

  logic [IDW:0]       cand_res, isr_res;
  logic               cand_found, isr_found;
  logic [IDW-1:0]     cand_idx, isr_top, eoi_ch;
  logic               eligible, ack, eoi_hit;
  logic [NUM_IRQ-1:0] ack_sel, eoi_sel, set_mask, lvl_clr;

  // Scan from lowest to highest priority so the last hit is the winner.
  function automatic logic [IDW:0] pick_highest(input logic [NUM_IRQ-1:0] bits,
                                                input logic [IDW-1:0]     lp);
    logic [IDW:0]   res;
    logic [IDW-1:0] idx;
    int             ch;
    res = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      ch = int'(lp) + 1 + k;
      if (ch >= NUM_IRQ) ch = ch - NUM_IRQ;
      idx = IDW'(ch);
      if (bits[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // 0 = highest priority, NUM_IRQ-1 = the current lowest_prio channel.
  function automatic int rank_of(input logic [IDW-1:0] ch, input logic [IDW-1:0] lp);
    int r;
    r = int'(ch) - int'(lp) - 1;
    if (r < 0) r = r + NUM_IRQ;
    return r;
  endfunction

  function automatic logic [NUM_IRQ-1:0] decode(input logic [IDW-1:0] ch);
    logic [NUM_IRQ-1:0] oh;
    oh = '0;
    for (int c = 0; c < NUM_IRQ; c++) begin
      if (ch == IDW'(c)) oh[c] = 1'b1;
    end
    return oh;
  endfunction

  always_comb begin
    cand_res   = pick_highest(irr_q & ~imr, lowest_q);
    cand_found = cand_res[IDW];
    cand_idx   = cand_res[IDW-1:0];
    isr_res    = pick_highest(isr_q, lowest_q);
    isr_found  = isr_res[IDW];
    isr_top    = isr_res[IDW-1:0];

    eligible = cand_found &&
               (!isr_found || (rank_of(cand_idx, lowest_q) < rank_of(isr_top, lowest_q)));
    ack      = (state_q == PEND) && inta && eligible;
    ack_sel  = ack ? decode(cand_idx) : '0;

    // Out-of-range specific levels decode to nothing, so they fall out as no-ops.
    eoi_ch   = eoi_specific ? eoi_level : isr_top;
    eoi_sel  = '0;
    if (eoi_valid && (eoi_specific || isr_found)) eoi_sel = decode(eoi_ch) & isr_q;
    eoi_hit  = |eoi_sel;

    set_mask = level_mode ? irq_in : (irq_in & ~irq_prev_q);
    lvl_clr  = level_mode ? (~irq_in & ~isr_q) : '0;
    irr_d    = (irr_q & ~ack_sel & ~lvl_clr) | set_mask;
    isr_d    = (isr_q & ~eoi_sel) | (auto_eoi ? '0 : ack_sel);

    lowest_d = lowest_q;
    if (auto_rotate) begin
      if (ack && auto_eoi) lowest_d = cand_idx;
      else if (eoi_hit)    lowest_d = eoi_ch;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      irr_q      <= '0;
      isr_q      <= '0;
      irq_prev_q <= '0;
      lowest_q   <= IDW'(NUM_IRQ - 1);
      int_req_q  <= 1'b0;
      vld_q      <= 1'b0;
      vector_q   <= '0;
    end else begin
      irr_q      <= irr_d;
      isr_q      <= isr_d;
      irq_prev_q <= irq_in;
      lowest_q   <= lowest_d;
      vld_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (eligible) begin
            state_q   <= PEND;
            int_req_q <= 1'b1;
          end
        end
        PEND: begin
          if (ack) begin
            state_q   <= ACK;
            int_req_q <= 1'b0;
            vld_q     <= 1'b1;
            vector_q  <= vector_base + VEC_W'(cand_idx);
          end else if (!eligible) begin
            state_q   <= IDLE;
            int_req_q <= 1'b0;
          end
        end
        ACK: begin
          state_q   <= eligible ? PEND : IDLE;
          int_req_q <= eligible;
        end
        default: begin
          state_q   <= IDLE;
          int_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign int_req      = int_req_q;
  assign vector_valid = vld_q;
  assign vector       = vector_q;
  assign irr          = irr_q;
  assign isr          = isr_q;
  assign lowest_prio  = lowest_q;

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Directed bench for irq_priority_ctrl: a per-cycle vector table plus hand-written
// sequences for same-cycle EOI/ack, edge-during-ack and asynchronous reset.
module tb_irq_priority_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] irq_in = '0;
  logic       level_mode = 1'b0;
  logic [7:0] imr = '0;
  logic       auto_rotate = 1'b0;
  logic       auto_eoi = 1'b0;
  logic       eoi_valid = 1'b0;
  logic       eoi_specific = 1'b0;
  logic [2:0] eoi_level = '0;
  logic [7:0] vector_base = 8'h20;
  logic       inta = 1'b0;
  logic       int_req;
  logic       vector_valid;
  logic [7:0] vector;
  logic [7:0] irr;
  logic [7:0] isr;
  logic [2:0] lowest_prio;

  int checks = 0;
  int errors = 0;

  irq_priority_ctrl #(.NUM_IRQ(8), .VEC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .level_mode(level_mode), .imr(imr),
    .auto_rotate(auto_rotate), .auto_eoi(auto_eoi), .eoi_valid(eoi_valid),
    .eoi_specific(eoi_specific), .eoi_level(eoi_level), .vector_base(vector_base),
    .inta(inta), .int_req(int_req), .vector_valid(vector_valid), .vector(vector),
    .irr(irr), .isr(isr), .lowest_prio(lowest_prio)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [7:0] irq;
    logic       lvl;
    logic [7:0] imr;
    logic       arot;
    logic       aeoi;
    logic       eoi_v;
    logic       eoi_s;
    logic [2:0] eoi_l;
    logic       inta;
    logic       e_ir;
    logic       e_vv;
    logic [7:0] e_vec;
    logic [7:0] e_irr;
    logic [7:0] e_isr;
    logic [2:0] e_lp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [7:0] q, input logic lv, input logic [7:0] m,
                     input logic ar, input logic ae, input logic ev, input logic es,
                     input logic [2:0] el, input logic ia, input logic xir, input logic xvv,
                     input logic [7:0] xvec, input logic [7:0] xirr, input logic [7:0] xisr,
                     input logic [2:0] xlp);
    vec_t v;
    v.rst_n = r;  v.irq = q;   v.lvl = lv;  v.imr = m;   v.arot = ar;  v.aeoi = ae;
    v.eoi_v = ev; v.eoi_s = es; v.eoi_l = el; v.inta = ia;
    v.e_ir = xir; v.e_vv = xvv; v.e_vec = xvec; v.e_irr = xirr; v.e_isr = xisr; v.e_lp = xlp;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    irq_in = '0; level_mode = 1'b0; imr = '0; auto_rotate = 1'b0; auto_eoi = 1'b0;
    eoi_valid = 1'b0; eoi_specific = 1'b0; eoi_level = '0; inta = 1'b0;
  endtask

  task automatic do_reset();
    clear_ctrl();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    //   rst irq    lv imr   ar ae ev es el  ia | ir vv vec    irr    isr    lp
    // Basic edge-mode acknowledge of IR3
    add(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 0,  0, 0, 8'h00, 8'h00, 8'h00, 7);
    add(1, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 0,  0, 0, 8'h00, 8'h00, 8'h00, 7);
    add(1, 8'h08, 0, 8'h00, 0, 0, 0, 0, 0, 0,  0, 0, 8'h00, 8'h08, 8'h00, 7);
    add(1, 8'h08, 0, 8'h00, 0, 0, 0, 0, 0, 0,  1, 0, 8'h00, 8'h08, 8'h00, 7);
    add(1, 8'h08, 0, 8'h00, 0, 0, 0, 0, 0, 1,  0, 1, 8'h23, 8'h00, 8'h08, 7);
    add(1, 8'h08, 0, 8'h00, 0, 0, 0, 0, 0, 0,  0, 0, 8'h23, 8'h00, 8'h08, 7);
    // Fully nested: IR5 blocked by IR3, IR1 nests, non-specific EOI clears IR1
    add(1, 8'h28, 0, 8'h00, 0, 0, 0, 0, 0, 0,  0, 0, 8'h23, 8'h20, 8'h08, 7);
    add(1, 8'h28, 0, 8'h00, 0, 0, 0, 0, 0, 0,  0, 0, 8'h23, 8'h20, 8'h08, 7);
    add(1, 8'h2A, 0, 8'h00, 0, 0, 0, 0, 0, 0,  0, 0, 8'h23, 8'h22, 8'h08, 7);
    add(1, 8'h2A, 0, 8'h00, 0, 0, 0, 0, 0, 0,  1, 0, 8'h23, 8'h22, 8'h08, 7);
    add(1, 8'h2A, 0, 8'h00, 0, 0, 0, 0, 0, 1,  0, 1, 8'h21, 8'h20, 8'h0A, 7);
    add(1, 8'h2A, 0, 8'h00, 0, 0, 1, 0, 0, 0,  0, 0, 8'h21, 8'h20, 8'h08, 7);
    add(1, 8'h2A, 0, 8'h00, 0, 0, 0, 0, 0, 0,  0, 0, 8'h21, 8'h20, 8'h08, 7);
    // Auto-rotate: EOI of IR2 makes it lowest, so IR4 beats IR1
    add(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 0,  0, 0, 8'h00, 8'h00, 8'h00, 7);
    add(1, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0, 0,  0, 0, 8'h00, 8'h00, 8'h00, 7);
    add(1, 8'h04, 0, 8'h00, 1, 0, 0, 0, 0, 0,  0, 0, 8'h00, 8'h04, 8'h00, 7);
    add(1, 8'h04, 0, 8'h00, 1, 0, 0, 0, 0, 0,  1, 0, 8'h00, 8'h04, 8'h00, 7);
    add(1, 8'h04, 0, 8'h00, 1, 0, 0, 0, 0, 1,  0, 1, 8'h22, 8'h00, 8'h04, 7);
    add(1, 8'h04, 0, 8'h00, 1, 0, 1, 0, 0, 0,  0, 0, 8'h22, 8'h00, 8'h00, 2);
    add(1, 8'h16, 0, 8'h00, 1, 0, 0, 0, 0, 0,  0, 0, 8'h22, 8'h12, 8'h00, 2);
    add(1, 8'h16, 0, 8'h00, 1, 0, 0, 0, 0, 0,  1, 0, 8'h22, 8'h12, 8'h00, 2);
    add(1, 8'h16, 0, 8'h00, 1, 0, 0, 0, 0, 1,  0, 1, 8'h24, 8'h02, 8'h10, 2);
    add(1, 8'h16, 0, 8'h00, 1, 0, 0, 0, 0, 0,  0, 0, 8'h24, 8'h02, 8'h10, 2);
    // Auto-EOI with IR0 masked, then unmasked
    add(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 0,  0, 0, 8'h00, 8'h00, 8'h00, 7);
    add(1, 8'h00, 0, 8'h01, 0, 1, 0, 0, 0, 0,  0, 0, 8'h00, 8'h00, 8'h00, 7);
    add(1, 8'h03, 0, 8'h01, 0, 1, 0, 0, 0, 0,  0, 0, 8'h00, 8'h03, 8'h00, 7);
    add(1, 8'h03, 0, 8'h01, 0, 1, 0, 0, 0, 0,  1, 0, 8'h00, 8'h03, 8'h00, 7);
    add(1, 8'h03, 0, 8'h01, 0, 1, 0, 0, 0, 1,  0, 1, 8'h21, 8'h01, 8'h00, 7);
    add(1, 8'h03, 0, 8'h00, 0, 1, 0, 0, 0, 0,  1, 0, 8'h21, 8'h01, 8'h00, 7);
    add(1, 8'h03, 0, 8'h00, 0, 1, 0, 0, 0, 1,  0, 1, 8'h20, 8'h00, 8'h00, 7);
    add(1, 8'h03, 0, 8'h00, 0, 1, 0, 0, 0, 0,  0, 0, 8'h20, 8'h00, 8'h00, 7);
    // Level mode: IR6 drops before inta, late inta ignored
    add(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 0,  0, 0, 8'h00, 8'h00, 8'h00, 7);
    add(1, 8'h00, 1, 8'h00, 0, 0, 0, 0, 0, 0,  0, 0, 8'h00, 8'h00, 8'h00, 7);
    add(1, 8'h40, 1, 8'h00, 0, 0, 0, 0, 0, 0,  0, 0, 8'h00, 8'h40, 8'h00, 7);
    add(1, 8'h40, 1, 8'h00, 0, 0, 0, 0, 0, 0,  1, 0, 8'h00, 8'h40, 8'h00, 7);
    add(1, 8'h00, 1, 8'h00, 0, 0, 0, 0, 0, 0,  1, 0, 8'h00, 8'h00, 8'h00, 7);
    add(1, 8'h00, 1, 8'h00, 0, 0, 0, 0, 0, 0,  0, 0, 8'h00, 8'h00, 8'h00, 7);
    add(1, 8'h00, 1, 8'h00, 0, 0, 0, 0, 0, 1,  0, 0, 8'h00, 8'h00, 8'h00, 7);
    add(1, 8'h00, 1, 8'h00, 0, 0, 0, 0, 0, 0,  0, 0, 8'h00, 8'h00, 8'h00, 7);

    for (int i = 0; i < tbl.size(); i++) begin
      rst_n = tbl[i].rst_n;  irq_in = tbl[i].irq;   level_mode = tbl[i].lvl;
      imr = tbl[i].imr;      auto_rotate = tbl[i].arot; auto_eoi = tbl[i].aeoi;
      eoi_valid = tbl[i].eoi_v; eoi_specific = tbl[i].eoi_s; eoi_level = tbl[i].eoi_l;
      inta = tbl[i].inta;
      step();
      chk($sformatf("row%0d.int_req", i),      int'(int_req),      int'(tbl[i].e_ir));
      chk($sformatf("row%0d.vector_valid", i), int'(vector_valid), int'(tbl[i].e_vv));
      chk($sformatf("row%0d.vector", i),       int'(vector),       int'(tbl[i].e_vec));
      chk($sformatf("row%0d.irr", i),          int'(irr),          int'(tbl[i].e_irr));
      chk($sformatf("row%0d.isr", i),          int'(isr),          int'(tbl[i].e_isr));
      chk($sformatf("row%0d.lowest_prio", i),  int'(lowest_prio),  int'(tbl[i].e_lp));
    end

    // Same-cycle specific EOI of IR3 and acknowledge of IR0
    do_reset();
    irq_in = 8'h08; step(); step();
    inta = 1'b1; step(); inta = 1'b0;
    chk("seq1.isr_ir3", int'(isr), 8'h08);
    step();
    irq_in = 8'h09; step(); step();
    chk("seq1.int_req_ir0", int'(int_req), 1);
    inta = 1'b1; eoi_valid = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd3;
    step();
    inta = 1'b0; eoi_valid = 1'b0; eoi_specific = 1'b0;
    chk("seq1.isr", int'(isr), 8'h01);
    chk("seq1.vector", int'(vector), 8'h20);
    chk("seq1.vector_valid", int'(vector_valid), 1);
    chk("seq1.irr", int'(irr), 8'h00);

    // Both EOI and auto-EOI ack want to rotate: the ack channel wins
    do_reset();
    auto_rotate = 1'b1;
    irq_in = 8'h08; step(); step();
    inta = 1'b1; step(); inta = 1'b0;
    step();
    auto_eoi = 1'b1;
    irq_in = 8'h09; step(); step();
    inta = 1'b1; eoi_valid = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd3;
    step();
    inta = 1'b0; eoi_valid = 1'b0; eoi_specific = 1'b0;
    chk("seq2.isr", int'(isr), 8'h00);
    chk("seq2.lowest_prio", int'(lowest_prio), 0);

    // Rising edge on IR0 in the very cycle IR0 is acknowledged
    do_reset();
    irq_in = 8'h01; step();
    irq_in = 8'h00; step();
    chk("seq3.int_req", int'(int_req), 1);
    irq_in = 8'h01; inta = 1'b1; step(); inta = 1'b0;
    chk("seq3.irr_kept", int'(irr), 8'h01);
    chk("seq3.isr", int'(isr), 8'h01);
    step();
    chk("seq3.equal_prio_no_req", int'(int_req), 0);
    step();
    chk("seq3.equal_prio_no_req2", int'(int_req), 0);

    // Asynchronous reset while PEND, with rotated priority and a held vector
    do_reset();
    auto_rotate = 1'b1; auto_eoi = 1'b1;
    irq_in = 8'h04; step(); step();
    inta = 1'b1; step(); inta = 1'b0;
    chk("seq4.vector", int'(vector), 8'h22);
    chk("seq4.lowest_prio", int'(lowest_prio), 2);
    step();
    irq_in = 8'h06; step(); step();
    chk("seq4.int_req", int'(int_req), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("seq4.rst_int_req", int'(int_req), 0);
    chk("seq4.rst_vector_valid", int'(vector_valid), 0);
    chk("seq4.rst_vector", int'(vector), 0);
    chk("seq4.rst_irr", int'(irr), 0);
    chk("seq4.rst_isr", int'(isr), 0);
    chk("seq4.rst_lowest_prio", int'(lowest_prio), 7);
    step();
    rst_n = 1'b1;
    clear_ctrl();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
